fetch_unit: RTL
===============

# fetch_unit

Front-end fetch stage of the OoO core. It owns the program counter and drives the instruction BRAM, which has a 1-cycle read latency. It presents one instruction per cycle to the fetch→decode skid buffer over a valid/ready handshake. It holds the returned BRAM data across downstream stalls and restarts fetch at a new PC when a redirect arrives from the branch unit or the ROB flush path.

## Interface
Parameters:
- PC_W, 32, PC width in bits (byte address).
- ADDR_W, 9, instruction-memory word-address width (512 words).
- RESET_PC, 0, PC fetched first after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- redirect_valid  in  1  mispredict/flush; restart fetch at redirect_pc.
- redirect_pc  in  PC_W  restart target; bits [1:0] are ignored and treated as 0.
- imem_en  out  1  BRAM read enable.
- imem_addr  out  ADDR_W  BRAM word address, pc[ADDR_W+1:2].
- imem_rdata  in  32  BRAM data, valid the cycle after an enabled read.
- fetch_to_skid_valid  out  1  output instruction valid.
- fetch_to_skid_pc  out  PC_W  PC of the output instruction.
- fetch_to_skid_instr  out  32  output instruction word.
- fetch_to_skid_ready  in  1  skid buffer accepts this cycle.
- fetch_count  out  32  number of instructions accepted downstream (performance counter).

## Operation
- Registers:
  - pc_q: next PC to request.
  - f2_valid, f2_pc: an outstanding or returned request.
  - hold_valid, hold_instr: BRAM data captured during a stall.
  - fetch_count.
- Accept = fetch_to_skid_valid && fetch_to_skid_ready.
- adv = !redirect_valid && (!f2_valid || fetch_to_skid_ready).
- When adv:
  - imem_en=1 and imem_addr=pc_q[ADDR_W+1:2], both combinational.
  - Next cycle: f2_valid←1, f2_pc←pc_q, pc_q←pc_q+4 (wraps mod 2^PC_W), hold_valid←0.
- Stall (!adv, no redirect, f2_valid):
  - imem_en=0.
  - If !hold_valid: hold_instr←imem_rdata and hold_valid←1.
  - Otherwise hold_instr is unchanged.
- Outputs:
  - fetch_to_skid_valid = f2_valid && !redirect_valid.
  - fetch_to_skid_pc = f2_pc.
  - fetch_to_skid_instr = hold_valid ? hold_instr : imem_rdata.
- Redirect has top priority:
  - imem_en=0 and output valid is forced to 0 in that cycle.
  - Next cycle: pc_q←{redirect_pc[PC_W-1:2],2'b00}, f2_valid←0, hold_valid←0.
  - An instruction presented in the redirect cycle is never accepted and is not counted.
- A redirect together with ready=1 still squashes the output.
- Back-to-back redirects: the last one wins, and no fetch is issued until one cycle with no redirect.
- fetch_count increments by 1 on each accept and wraps at 2^32.
- Upper PC bits above ADDR_W+1 do not reach the memory; the address aliases modulo 512 words.

## Timing
- Reset (rst=1 at a clk edge): pc_q=RESET_PC, f2_valid=0, hold_valid=0, hold_instr=0, fetch_count=0.
- Resulting output values during reset:
  - fetch_to_skid_valid=0, fetch_to_skid_pc=0.
  - imem_en is forced to 0 while rst=1.
  - fetch_to_skid_instr=imem_rdata (undefined, ignored).
- Reset mid-stall or mid-redirect discards all state.
- First cycle after reset release (cycle 0): imem_en=1, imem_addr=RESET_PC>>2.
- Cycle 1: valid=1 with the RESET_PC instruction.
- Steady state with ready held high: 1 instruction per cycle, PCs consecutive +4.
- Fetch latency is 1 cycle from request to valid output.
- Redirect penalty: the redirect is asserted in cycle R; the target is requested in R+1 and is valid in R+2.
- Stall: valid, pc and instr stay stable every cycle while ready=0.
- Once ready rises, the held instruction is accepted that cycle and the next request is issued in the same cycle.
- With no stall, the next instruction is valid the cycle after acceptance.

## Test plan
- Reset then ready=1, memory preloaded with mem[k]=0x100+k → outputs PC 0,4,8,… with instr 0x100,0x101,… on consecutive cycles starting 1 cycle after reset release; fetch_count=8 after 8 accepts.
- Drop ready for 3 cycles while PC 0x08 is valid and change BRAM data under it → PC 0x08/instr 0x102 held stable with imem_en=0; on ready=1 PC 0x08 is accepted and PC 0x0C follows next cycle.
- Redirect to 0x40 while PC 0x10 is valid with ready=1 → valid=0 that cycle; PC 0x10 is not counted; PC 0x40 is valid 2 cycles later, then 0x44.
- Redirect to 0x23 → fetch resumes at 0x20 (low bits cleared).
- Redirect on two consecutive cycles (0x80 then 0xC0) → 0x80 is never presented; 0xC0 is valid 2 cycles after the second redirect.
- Assert rst for 1 cycle during a stall with hold_valid=1 → all outputs return to reset values and fetch restarts at RESET_PC with fetch_count=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives a 1-cycle-latency instruction BRAM and feeds
// the decode skid buffer, holding returned data across stalls and honouring redirects.
module fetch_unit #(
    parameter int              PC_W     = 32,
    parameter int              ADDR_W   = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              fetch_to_skid_valid,
    output logic [PC_W-1:0]   fetch_to_skid_pc,
    output logic [31:0]       fetch_to_skid_instr,
    input  logic              fetch_to_skid_ready,
    output logic [31:0]       fetch_count
);

    logic [PC_W-1:0] r_pc;
    logic            r_f2_valid;
    logic [PC_W-1:0] r_f2_pc;
    logic            r_hold_valid;
    logic [31:0]     r_hold_instr;
    logic [31:0]     r_fetch_count;

    logic            w_adv;
    logic            w_accept;

    // Advance whenever the stage is empty or its current instruction leaves this cycle.
    assign w_adv    = !redirect_valid && (!r_f2_valid || fetch_to_skid_ready);
    assign w_accept = fetch_to_skid_valid && fetch_to_skid_ready;

    assign imem_en             = w_adv && !rst;
    assign imem_addr           = r_pc[ADDR_W+1:2];
    assign fetch_to_skid_valid = r_f2_valid && !redirect_valid;
    assign fetch_to_skid_pc    = r_f2_pc;
    assign fetch_to_skid_instr = r_hold_valid ? r_hold_instr : imem_rdata;
    assign fetch_count         = r_fetch_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_f2_valid    <= 1'b0;
            r_f2_pc       <= '0;
            r_hold_valid  <= 1'b0;
            r_hold_instr  <= '0;
            r_fetch_count <= '0;
        end else begin
            if (w_accept) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end

            if (redirect_valid) begin
                r_pc         <= {redirect_pc[PC_W-1:2], 2'b00};
                r_f2_valid   <= 1'b0;
                r_hold_valid <= 1'b0;
            end else if (w_adv) begin
                r_f2_valid   <= 1'b1;
                r_f2_pc      <= r_pc;
                r_pc         <= r_pc + PC_W'(4);
                r_hold_valid <= 1'b0;
            end else if (!r_hold_valid) begin
                // BRAM data is only valid one cycle after the read; capture it on the first stall cycle.
                r_hold_instr <= imem_rdata;
                r_hold_valid <= 1'b1;
            end
        end
    end

endmodule
